// File: rtl/rom_slot_update.sv
// Two-cartridge slot mapper: snapshots ROM download info and writes one
// {valid, mapper, base, mask} entry per cartridge into the slot config table.
//
// state | meaning
// IDLE  | waiting for update_request
// SNAP  | capture rom0/rom1 inputs, clear overflow, select cart 0
// CALC  | derive block count and validity for the current cart
// MASK  | grow the power-of-two-minus-one mask until it covers the image
// WRITE | hold cfg_we/cfg_addr/cfg_data until cfg_ready
// NEXT  | advance to cart 1, or finish
// ACK   | one-cycle update_ack pulse
module rom_slot_update #(
    parameter int BLOCK_BITS = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_request,
    output logic        update_ack,
    input  logic        rom0_loaded,
    input  logic        rom1_loaded,
    input  logic [4:0]  rom0_mapper,
    input  logic [4:0]  rom1_mapper,
    input  logic [24:0] rom0_size,
    input  logic [24:0] rom1_size,
    output logic        cfg_we,
    input  logic        cfg_ready,
    output logic        cfg_addr,
    output logic [29:0] cfg_data,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SNAP, ST_CALC, ST_MASK, ST_WRITE, ST_NEXT, ST_ACK
    } state_t;

    localparam logic [24:0] LOW_MASK   = (25'd1 << BLOCK_BITS) - 25'd1;
    localparam logic [12:0] SPACE_BLKS = 13'd2048;

    state_t      state_q;
    logic        ack_q;
    logic        we_q;
    logic        addr_q;
    logic [29:0] data_q;
    logic        ovf_q;

    logic        loaded0_q, loaded1_q;
    logic [4:0]  mapper0_q, mapper1_q;
    logic [24:0] size0_q, size1_q;

    logic        cart_q;
    logic [11:0] blocks_q;
    logic [11:0] mask_q;
    logic        valid_q;
    logic [11:0] mask0_q;
    logic        valid0_q;

    logic [24:0] size_sel;
    logic        loaded_sel;
    logic [4:0]  mapper_sel;
    logic [11:0] blocks_d;
    logic [11:0] base_d;
    logic [12:0] span_d;
    logic        fits_d;
    logic        entry_ok;
    logic [29:0] data_d;
    logic        mask_done;

    always_comb begin
        size_sel   = cart_q ? size1_q   : size0_q;
        loaded_sel = cart_q ? loaded1_q : loaded0_q;
        mapper_sel = cart_q ? mapper1_q : mapper0_q;
        blocks_d   = 12'(size_sel >> BLOCK_BITS) + {11'd0, |(size_sel & LOW_MASK)};
        base_d     = 12'd0;
        if (cart_q && valid0_q) begin
            base_d = mask0_q + 12'd1;
        end
        span_d    = {1'b0, base_d} + {1'b0, mask_q} + 13'd1;
        fits_d    = (span_d <= SPACE_BLKS);
        // Only cart 1 can run past the end; cart 0 always starts at block 0.
        entry_ok  = valid_q && (!cart_q || fits_d);
        data_d    = entry_ok ? {1'b1, mapper_sel, base_d, mask_q} : 30'd0;
        mask_done = !valid_q || (mask_q >= (blocks_q - 12'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 1'b0;
            data_q    <= 30'd0;
            ovf_q     <= 1'b0;
            loaded0_q <= 1'b0;
            loaded1_q <= 1'b0;
            mapper0_q <= 5'd0;
            mapper1_q <= 5'd0;
            size0_q   <= 25'd0;
            size1_q   <= 25'd0;
            cart_q    <= 1'b0;
            blocks_q  <= 12'd0;
            mask_q    <= 12'd0;
            valid_q   <= 1'b0;
            mask0_q   <= 12'd0;
            valid0_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (update_request) begin
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    loaded0_q <= rom0_loaded;
                    loaded1_q <= rom1_loaded;
                    mapper0_q <= rom0_mapper;
                    mapper1_q <= rom1_mapper;
                    size0_q   <= rom0_size;
                    size1_q   <= rom1_size;
                    ovf_q     <= 1'b0;
                    cart_q    <= 1'b0;
                    state_q   <= ST_CALC;
                end
                ST_CALC: begin
                    blocks_q <= blocks_d;
                    valid_q  <= loaded_sel && (blocks_d != 12'd0);
                    mask_q   <= 12'd0;
                    state_q  <= ST_MASK;
                end
                ST_MASK: begin
                    if (mask_done) begin
                        data_q  <= data_d;
                        addr_q  <= cart_q;
                        we_q    <= 1'b1;
                        state_q <= ST_WRITE;
                        if (!cart_q) begin
                            mask0_q  <= mask_q;
                            valid0_q <= valid_q;
                        end else if (valid_q && !fits_d) begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        mask_q <= {mask_q[10:0], 1'b1};
                    end
                end
                ST_WRITE: begin
                    if (cfg_ready) begin
                        we_q    <= 1'b0;
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!cart_q) begin
                        cart_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign update_ack = ack_q;
    assign cfg_we     = we_q;
    assign cfg_addr   = addr_q;
    assign cfg_data   = data_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
